// File: rtl/stream_mux_rr_pkg.sv
// mux_pkg: shared constants and helpers for stream_mux_rr.
//   MODE_FIXED / MODE_RR : values of the mode input.
//   sel_width(n)         : width of a channel index for n channels (min 1).
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: bundles the producer-side and consumer-side handshakes
// of stream_mux_rr, plus the mode/sel controls.
//   slave  : the mux view (takes inputs, drives in_ready and out_*).
//   master : the environment view (drives inputs, out_ready and controls).
interface stream_mux_rr_if
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8
);
    localparam int SEL_W = sel_width(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational cyclic priority search.
//   req     : per-channel request vector.
//   ptr     : last granted channel; search starts at ptr+1 and wraps to ptr.
//   gnt_idx : granted channel (0 when gnt_any is low).
//   gnt_any : at least one request present.
// The request vector is duplicated so the wrapped search becomes a linear
// scan over positions ptr+1 .. ptr+N_CH with no modulo in the index path.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [2*N_CH-1:0] req_dbl;

    always_comb begin
        req_dbl = {req, req};
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            int pos;
            pos = int'(ptr) + i;
            if (!gnt_any && pos < 2*N_CH && req_dbl[pos]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'((pos >= N_CH) ? pos - N_CH : pos);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 stream multiplexer with a single registered
// output slot, fixed-select or round-robin arbitration.
//   clk, rst_n : rising-edge clock, synchronous active-low reset.
//   bus        : stream_mux_rr_if.slave (in_data/in_valid/in_ready,
//                mode/sel, out_data/out_ch/out_valid/out_ready).
// in_ready depends combinationally on out_ready, in_valid, mode and sel;
// in_data only reaches the output through the register.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 8,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] rr_idx, gnt_idx;
    logic             rr_any, gnt_any, fixed_ok;
    logic             load_en, xfer;
    logic [N_CH-1:0]  ready_vec;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        // Compare against every legal index so an out-of-range sel never
        // indexes past in_valid and simply yields no grant.
        fixed_ok = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.sel == SEL_W'(k) && bus.in_valid[k]) fixed_ok = 1'b1;
        end

        if (bus.mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end else begin
            gnt_idx = bus.sel;
            gnt_any = fixed_ok;
        end

        load_en = !out_valid_q || bus.out_ready;
        // Reset gating keeps producers from seeing a handshake in the reset cycle.
        xfer    = rst_n && load_en && gnt_any;

        ready_vec = '0;
        gnt_data  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                ready_vec[k] = xfer;
                gnt_data     = bus.in_data[k*WIDTH +: WIDTH];
            end
        end

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (xfer) begin
                out_data_d  = gnt_data;
                out_ch_d    = gnt_idx;
                out_valid_d = 1'b1;
                if (bus.mode == MODE_RR) ptr_d = gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            // Last-granted = N_CH-1 gives channel 0 first round-robin priority.
            ptr_q       <= SEL_W'(N_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst_n;
    logic rst5_n;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.N_CH(8), .WIDTH(8)) a ();
    stream_mux_rr_if #(.N_CH(5), .WIDTH(8)) b ();

    stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(a));
    stream_mux_rr #(.N_CH(5), .WIDTH(8)) dut5 (.clk(clk), .rst_n(rst5_n), .bus(b));

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model of the 8-channel instance: one output slot and the
    // last round-robin winner, advanced once per cycle from sampled inputs.
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_ch    = 0;
    int         m_ptr   = 7;

    function automatic int model_grant();
        if (a.mode == 1'b0) return a.in_valid[a.sel] ? int'(a.sel) : -1;
        for (int i = 1; i <= 8; i++) begin
            int c;
            c = (m_ptr + i) % 8;
            if (a.in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int         g;
            bit         load;
            logic [7:0] e_rdy;
            g     = model_grant();
            load  = !m_valid || a.out_ready;
            e_rdy = '0;
            if (rst_n && load && g >= 0) e_rdy[g] = 1'b1;
            chk("m_in_ready", a.in_ready, e_rdy);
            chk("m_out_valid", a.out_valid, m_valid);
            chk("m_out_data", a.out_data, m_data);
            chk("m_out_ch", a.out_ch, m_ch);
            if (!rst_n) begin
                m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 7;
            end else if (load) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = a.in_data[g*8 +: 8];
                    m_ch    = g;
                    if (a.mode) m_ptr = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0] held_d;
        logic [2:0] held_c;
        rst_n = 1'b0; rst5_n = 1'b0;
        a.mode = 1'b0; a.sel = '0; a.in_valid = 8'hFF; a.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) a.in_data[k*8 +: 8] = 8'(8'h10 + k);
        b.mode = 1'b0; b.sel = '0; b.in_valid = 5'h1F; b.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) b.in_data[k*8 +: 8] = 8'(8'h30 + k);

        // Reset held two cycles with every channel valid.
        @(posedge clk); chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_in_ready", a.in_ready, 0);
        chk("rst_out_data", a.out_data, 0);
        chk("rst_out_ch", a.out_ch, 0);

        // Fixed select of channel 5.
        @(posedge clk); #1 rst_n = 1'b1; a.sel = 3'd5;
        @(negedge clk);
        chk("fix_in_ready0", a.in_ready, 8'h20);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fix_out_data", a.out_data, 8'h15);
            chk("fix_out_ch", a.out_ch, 5);
            chk("fix_in_ready", a.in_ready, 8'h20);
        end

        // Round-robin, all valid: ptr still 7, so 0..7 twice.
        @(posedge clk); #1 a.mode = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("rr_out_ch", a.out_ch, i % 8);
            chk("rr_out_valid", a.out_valid, 1);
        end

        // Sparse round-robin on channels 2 and 7 (one all-valid load of ch0 first).
        @(posedge clk); #1 a.in_valid = 8'b1000_0100;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("sparse_out_ch", a.out_ch, (i % 2) ? 7 : 2);
        end

        // Backpressure: word for ch2 is held while out_ready is low.
        @(posedge clk); #1 a.out_ready = 1'b0;
        @(negedge clk);
        held_d = a.out_data; held_c = a.out_ch;
        chk("bp_held_ch", held_c, 2);
        chk("bp_held_data", held_d, 8'h12);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", a.in_ready, 0);
            chk("bp_stable_data", a.out_data, held_d);
            chk("bp_stable_ch", a.out_ch, held_c);
            @(negedge clk);
        end
        @(posedge clk); #1 a.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_ch", a.out_ch, 7);
        chk("bp_next_data", a.out_data, 8'h17);

        // 5-channel instance: out-of-range select, then reset during a stall.
        @(posedge clk); #1 rst5_n = 1'b1; b.sel = 3'd1;
        @(negedge clk);
        chk("n5_fix_ready", b.in_ready, 5'b00010);
        @(posedge clk); #1 b.sel = 3'd6;
        @(negedge clk);
        chk("n5_held_valid", b.out_valid, 1);
        chk("n5_held_ch", b.out_ch, 1);
        chk("n5_sel6_ready", b.in_ready, 0);
        @(negedge clk);
        chk("n5_sel6_drained", b.out_valid, 0);
        @(posedge clk); #1 b.mode = 1'b1; b.out_ready = 1'b0;
        @(negedge clk);
        chk("n5_rr_ready", b.in_ready, 5'b00001);
        @(negedge clk);
        chk("n5_stall_ch", b.out_ch, 0);
        chk("n5_stall_data", b.out_data, 8'h30);
        @(posedge clk); #1 rst5_n = 1'b0;
        @(negedge clk);
        chk("n5_rst_ready", b.in_ready, 0);
        @(negedge clk);
        chk("n5_rst_valid", b.out_valid, 0);
        chk("n5_rst_ch", b.out_ch, 0);
        @(posedge clk); #1 rst5_n = 1'b1; b.out_ready = 1'b1;
        @(negedge clk);
        chk("n5_post_ready", b.in_ready, 5'b00001);
        @(negedge clk);
        chk("n5_post_ch0", b.out_ch, 0);
        @(negedge clk);
        chk("n5_post_ch1", b.out_ch, 1);
        @(negedge clk);
        chk("n5_post_ch2", b.out_ch, 2);
        @(negedge clk);
        chk("n5_post_wrap_ch3", b.out_ch, 3);
        @(negedge clk);
        chk("n5_post_wrap_ch4", b.out_ch, 4);
        @(negedge clk);
        chk("n5_post_wrap_ch0", b.out_ch, 0);

        // Randomised traffic on the 8-channel instance against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            a.in_valid  = 8'($urandom);
            for (int k = 0; k < 8; k++) a.in_data[k*8 +: 8] = 8'($urandom);
            if ($urandom_range(0, 15) == 0) a.mode = ~a.mode;
            a.sel       = 3'($urandom);
            a.out_ready = ($urandom_range(0, 9) < 7);
            rst_n       = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer with a registered output and valid/ready handshakes on every port. It is the sequential successor to the fixed 8:1 combinational mux tree and selects among `N_CH` input streams of `WIDTH` bits. Selection is either software-directed (fixed select) or fair round-robin. It sits between multiple producer blocks and a single shared consumer, for example a shared UART TX or a display driver.

## Interface
Parameters:
- `N_CH`, default 8: number of input channels, 2..16.
- `WIDTH`, default 8: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: select / channel-ID width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `in_data`, input, `N_CH*WIDTH`: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_valid`, input, `N_CH`: per-channel valid.
- `in_ready`, output, `N_CH`: per-channel ready, one-hot or zero.
- `mode`, input, 1: 0 = fixed select via `sel`; 1 = round-robin.
- `sel`, input, `SEL_W`: channel index used when `mode`=0.
- `out_data`, output, `WIDTH`: registered data.
- `out_ch`, output, `SEL_W`: source channel of `out_data`.
- `out_valid`, output, 1: output register holds a word.
- `out_ready`, input, 1: consumer accepts the word.

## Operation
- Single-entry output register. `load_en` = `!out_valid || out_ready`.
- Grant is computed combinationally each cycle:
  - `mode`=0: grant = `sel`, only if `sel` < `N_CH` and `in_valid[sel]`. Otherwise no grant.
  - `mode`=1: grant = first channel with `in_valid` set, searching cyclically from `ptr+1` through `ptr`.
- `in_ready[g]` = `load_en` for the granted channel g only. All other `in_ready` bits are 0. With no grant, `in_ready` is all zero.
- Transfer on input g occurs when `in_valid[g] && in_ready[g]`. On that edge: `out_data` ← channel g data, `out_ch` ← g, `out_valid` ← 1.
- On `load_en` with no grant, `out_valid` ← 0. `out_data` and `out_ch` hold their values.
- `ptr` (`SEL_W` bits) updates to g only on an accepted input transfer in `mode`=1. It is unchanged in `mode`=0.
- Output words are never dropped or duplicated. `out_data`/`out_ch` remain stable while `out_valid && !out_ready`.
- A `mode` or `sel` change takes effect on the next grant decision. A word already in the output register is unaffected.
- `in_valid` may be deasserted by a producer without a transfer; the mux imposes no input-side stability requirement.

## Timing
- Reset values (`rst_n`=0 sampled at an edge): `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=`N_CH-1`, so channel 0 has first round-robin priority. `in_ready` is 0 during reset because it is gated by reset.
- Reset mid-operation discards any held output word. `in_ready` is 0 in the reset cycle.
- Latency: an input accepted at edge t appears on `out_valid`/`out_data` after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle when `out_ready` is held high. A simultaneous output drain and input load is allowed in the same cycle.
- Backpressure: while `out_valid && !out_ready`, all `in_ready` = 0.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode` and `sel`. There is no combinational path from `in_data` to any output.
- Round-robin: with all channels continuously valid and `out_ready`=1, grants cycle 0,1,…,N_CH-1,0 with no channel skipped or repeated.
- Wrap-around: search from `ptr`=`N_CH-1` starts at channel 0. `ptr` wraps modulo `N_CH`, including for non-power-of-2 `N_CH`.

## Structure
- Shared package `mux_pkg`: the `SEL_W` computation function (clog2 wrapper) and the mode constants `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
- One sub-module, `rr_arbiter`: combinational, parameter `N_CH`. Inputs are `req[N_CH-1:0]` and `ptr`. Outputs are `gnt_idx` and `gnt_any`. It implements the cyclic priority search using a double-width request vector.
- The top level contains the fixed/RR grant select, the `in_ready` decode, and the output and `ptr` registers.

## Test plan
1. Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1. Required: `out_valid`=0, `in_ready`=0, `out_data`=0, `out_ch`=0.
2. Fixed select: `mode`=0, `sel`=5, `in_valid`=8'hFF, channel k data = 8'h10+k, `out_ready`=1. Required: only `in_ready[5]`=1; `out_data`=8'h15 and `out_ch`=5 from the next cycle onward, every cycle.
3. Round-robin fairness: `mode`=1, all valid, `out_ready`=1 for 16 cycles. Required: `out_ch` sequence 0..7, 0..7, with `out_valid` continuously 1 from cycle 1.
4. Sparse round-robin: `mode`=1, `in_valid`=8'b1000_0100. Required: `out_ch` alternates 2, 7, 2, 7, and the wrap from 7 back to 2 is correct.
5. Backpressure: with a word held, drive `out_ready`=0 for 3 cycles, then 1. Required: `out_data`/`out_ch` stable and `in_ready`=0 throughout the stall; next word appears 1 cycle after release, with no loss.
6. Edge cases:
   - `N_CH`=5, `mode`=0, `sel`=6: no grant, and `out_valid` falls after draining.
   - Assert `rst_n`=0 while a word is stalled: word discarded, `ptr` returns to 4.
